// File: rtl/mem_ctrl_pkg.sv
// Shared types, size codes and state encodings for the unified RAM port controller.
package mem_ctrl_pkg;

  typedef logic [1:0]  mem_size_t;
  typedef logic [7:0]  ram_data_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] reg_t;

  localparam mem_size_t SIZE_B = 2'd0;
  localparam mem_size_t SIZE_H = 2'd1;
  localparam mem_size_t SIZE_W = 2'd2;

  localparam logic [1:0] MC_IDLE   = 2'd0;
  localparam logic [1:0] MC_IF_RD  = 2'd1;
  localparam logic [1:0] MC_MEM_RD = 2'd2;
  localparam logic [1:0] MC_MEM_WR = 2'd3;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_to_len(input mem_size_t size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundles the fetch, data and RAM-side signals of the memory controller.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_done;
  inst_t                 if_inst;

  logic                  mem_req;
  logic                  mem_we;
  mem_size_t             mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  reg_t                  mem_wdata;
  logic                  mem_done;
  reg_t                  mem_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  ram_data_t             ram_dout;
  ram_data_t             ram_din;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_we, ram_dout, busy
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_we, ram_dout, busy
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between fetch and MEM, sequencing multi-byte
// accesses one byte per cycle and assembling reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
)
(
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  logic [1:0]            state_reg;
  logic [2:0]            cnt_reg;
  logic [2:0]            len_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  reg_t                  wdata_reg;
  reg_t                  rbuf_reg;
  reg_t                  rbuf_merged;
  logic                  if_done_reg;
  logic                  mem_done_reg;
  inst_t                 if_inst_reg;
  reg_t                  mem_rdata_reg;
  logic                  issuing;
  logic                  writing;

  // The byte returning now belongs to the address issued one cycle ago (index cnt-1).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rbuf_merged[gi*8 +: 8] = (cnt_reg == 3'(gi + 1)) ? bus.ram_din
                                                              : rbuf_reg[gi*8 +: 8];
    end
  endgenerate

  assign issuing      = (state_reg != MC_IDLE) && (cnt_reg < len_reg);
  assign writing      = (state_reg == MC_MEM_WR);
  assign bus.ram_addr = issuing ? base_reg + ADDR_WIDTH'(cnt_reg) : '0;
  assign bus.ram_we   = writing;
  assign bus.ram_dout = writing ? wdata_reg[{cnt_reg[1:0], 3'b000} +: 8] : '0;
  assign bus.busy     = (state_reg != MC_IDLE);
  assign bus.if_done  = if_done_reg;
  assign bus.if_inst  = if_inst_reg;
  assign bus.mem_done = mem_done_reg;
  assign bus.mem_rdata = mem_rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= MC_IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      base_reg      <= '0;
      wdata_reg     <= '0;
      rbuf_reg      <= '0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      if_inst_reg   <= '0;
      mem_rdata_reg <= '0;
    end else begin
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      case (state_reg)
        MC_IDLE: begin
          // Holding off while a done pulse is out lets the requester drop req.
          if (!if_done_reg && !mem_done_reg) begin
            if (bus.mem_req) begin
              state_reg <= bus.mem_we ? MC_MEM_WR : MC_MEM_RD;
              len_reg   <= size_to_len(bus.mem_size);
              base_reg  <= bus.mem_addr;
              wdata_reg <= bus.mem_wdata;
              cnt_reg   <= '0;
              rbuf_reg  <= '0;
            end else if (bus.if_req && !bus.if_flush) begin
              state_reg <= MC_IF_RD;
              len_reg   <= 3'd4;
              base_reg  <= bus.if_addr;
              cnt_reg   <= '0;
              rbuf_reg  <= '0;
            end
          end
        end
        MC_IF_RD, MC_MEM_RD: begin
          if (state_reg == MC_IF_RD && bus.if_flush) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
          end else begin
            if (cnt_reg != 3'd0) begin
              rbuf_reg <= rbuf_merged;
            end
            if (cnt_reg == len_reg) begin
              state_reg <= MC_IDLE;
              cnt_reg   <= '0;
              if (state_reg == MC_IF_RD) begin
                if_inst_reg <= rbuf_merged;
                if_done_reg <= 1'b1;
              end else begin
                mem_rdata_reg <= rbuf_merged;
                mem_done_reg  <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 3'd1;
            end
          end
        end
        MC_MEM_WR: begin
          if (cnt_reg == len_reg - 3'd1) begin
            state_reg    <= MC_IDLE;
            cnt_reg      <= '0;
            mem_done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: begin
          state_reg <= MC_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide unified RAM port between instruction fetch (IF) and the MEM stage's loads and stores.
- Sequences multi-byte accesses one byte per cycle and assembles read bytes little-endian.
- Returns a one-cycle done pulse to the owning requester.
- Sits between the pipeline's IF and MEM stages and the external RAM. RAM reads have 1-cycle latency.

Parameters:
ADDR_WIDTH, 32, width of all byte addresses (`MemAddrBus`).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_done or if_flush
if_addr  in  ADDR_WIDTH  fetch byte address
if_flush  in  1  branch redirect; aborts an in-flight or pending fetch
if_done  out  1  one-cycle pulse, if_inst valid
if_inst  out  32  fetched instruction
mem_req  in  1  data request; held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mem_addr  in  ADDR_WIDTH  data byte address
mem_wdata  in  32  store data; bytes taken low to high
mem_done  out  1  one-cycle pulse, mem_rdata valid for loads
mem_rdata  out  32  raw load data, zero-extended; sign extension is done in MEM
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_we  out  1  RAM write enable
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid 1 cycle after its address
busy  out  1  high while not IDLE

Behaviour:
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt (0..4) and length N (1/2/4) are registered. Base address and write data are latched at acceptance.
- Reset (reset = 0, asynchronous): state IDLE, cnt 0. if_done, mem_done, ram_we, busy, ram_addr, ram_dout, if_inst and mem_rdata are all 0. Reset mid-access abandons it and ram_we drops immediately; no done is issued.
- Acceptance at edge t (IDLE only). Priority: mem_req first, then if_req when if_flush = 0.
  - No acceptance in a cycle where if_done or mem_done is high. This gives the requester time to drop req.
  - mem_we = 1 goes to MEM_WR; mem_we = 0 goes to MEM_RD; an IF request goes to IF_RD.
- Read (N bytes):
  - ram_addr = base + k during cycle [t+k, t+k+1), for k = 0..N-1, with ram_we = 0.
  - Byte k is sampled from ram_din at edge t+k+2 into bits [8k+7:8k]; unread upper bytes are 0.
  - Done is registered at edge t+N+1 and is high for cycle [t+N+1, t+N+2). State returns to IDLE at that same edge.
  - Word read latency is 5 cycles from the acceptance edge.
- Write (N bytes):
  - ram_we = 1, ram_addr = base + k, ram_dout = wdata[8k+7:8k] during cycle [t+k, t+k+1).
  - Done is high during [t+N, t+N+1). State returns to IDLE at edge t+N.
- Data hold: if_inst and mem_rdata hold their values after done until the next completed read for the same requester.
- Address arithmetic: base + k is modulo 2^ADDR_WIDTH, so wrap past all-ones continues at 0. No alignment check.
- if_flush behaviour:
  - High in IF_RD: abort at the next edge to IDLE, no if_done, if_inst unchanged. A late byte still returning from RAM is ignored.
  - Sampled in IDLE: suppresses IF acceptance that cycle.
  - No effect on MEM accesses.
- Simultaneous if_req and mem_req in IDLE: MEM wins, IF waits. IF may starve while MEM keeps requesting; this is by design, since the pipeline stalls on MEM.
- Requests are never dropped once accepted; mid-access request changes are ignored.
- ram_addr = 0 and ram_we = 0 whenever state is IDLE.

Decomposition:
- Add to define.v:
  - `MemSizeBus` [1:0], plus size codes `SizeB`/`SizeH`/`SizeW`.
  - State encodings `MC_IDLE`/`MC_IF_RD`/`MC_MEM_RD`/`MC_MEM_WR` (2 bits).
  - `RamDataBus` [7:0].
- Reuse the existing `MemAddrBus`, `InstBus` and `RegBus`.
- No sub-module: byte assembly and the counter sit inline in one state machine.

Test Plan:
- Reset: hold reset = 0 with both req high → all outputs 0, busy 0. Release reset → MEM accepted first.
- IF word read: if_addr = 0x100, RAM bytes 13 00 00 00 → ram_addr 0x100..0x103 on consecutive cycles; if_done pulse 5 cycles after acceptance; if_inst = 0x00000013.
- Contention: if_req and mem_req both high, mem SB (mem_size 0) at 0x30004, wdata 0xAB → ram_we 1 cycle with ram_dout 0xAB at 0x30004. mem_done at t+1. IF accepted 1 cycle after mem_done drops, if_done 5 cycles later.
- Halfword load wrap: mem_addr = 0xFFFFFFFF, mem_size 1 → ram_addr 0xFFFFFFFF then 0x00000000. mem_rdata = {16'h0, b1, b0}; mem_done at t+3.
- Flush: if_flush = 1 two cycles into IF_RD → IDLE next edge, no if_done, if_inst keeps its previous value. A new if_req at 0x200 completes normally.
- Reset mid SW: assert reset during byte 2 of a store → ram_we low immediately, no mem_done. After release, a repeated SW writes all 4 bytes.
